frame_rx: RTL and testbench

- Parametrised serial command receiver; successor to the fixed 4+4-bit front-panel receiver.
- Deserialises start / data field / instruction field / (parity) / stop frames from the single-wire `transmission` input.
- Decodes the instruction field and drives the LED mirror and the `display` register.
- Adds configurable field widths, oversampled mid-bit sampling, stop-bit checking, an accumulate instruction and frame status outputs.

---
 rtl/frame_rx_if.sv | 22 ++
 rtl/frame_rx.sv | 176 +++++++++++++++++
 tb/tb_frame_rx.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_rx_if.sv
// Serial command receiver bus: line input plus decoded outputs and frame status.
interface frame_rx_if #(
  parameter int DATA_W  = 4,
  parameter int INSTR_W = 4
);
  logic                      transmission;
  logic [DATA_W+INSTR_W-1:0] ledData;
  logic [DATA_W:0]           display;
  logic                      frameValid;
  logic                      frameError;
  logic                      busy;

  modport master (
    output transmission,
    input  ledData, display, frameValid, frameError, busy
  );

  modport slave (
    input  transmission,
    output ledData, display, frameValid, frameError, busy
  );
endinterface

// File: rtl/frame_rx.sv
// frame_rx: oversampled serial command receiver.
// Frame: start(0), data MSB-first, instruction MSB-first, [even parity], stop(1).
// Optional even-parity bit enabled by defining FRAME_RX_PARITY_EN.
//
// state | meaning
// IDLE  | line idle, waiting for a low start bit
// START | re-checking the start bit at mid-bit (glitch reject)
// SHIFT | sampling payload (and parity) bits at mid-bit
// STOP  | sampling the stop bit, checking parity
// EXEC  | latching the payload and executing the instruction
module frame_rx #(
  parameter int DATA_W       = 4,
  parameter int INSTR_W      = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic     clk2,
  input  logic     reset,
  frame_rx_if.slave bus
);

  localparam int PW = DATA_W + INSTR_W;
`ifdef FRAME_RX_PARITY_EN
  localparam int NBITS = PW + 1;
`else
  localparam int NBITS = PW;
`endif
  localparam int H   = CLKS_PER_BIT / 2;
  localparam int BCW = $clog2(NBITS + 1);

  localparam logic [7:0]         BIT_RELOAD  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]         HALF_RELOAD = 8'((H > 0) ? (H - 1) : 0);
  localparam logic [BCW-1:0]     LAST_IDX    = BCW'(NBITS - 1);
  localparam logic [DATA_W:0]    BLANK       = {1'b1, {DATA_W{1'b0}}};
  localparam logic [INSTR_W-1:0] OP_CLEAR    = INSTR_W'(1);
  localparam logic [INSTR_W-1:0] OP_ADD      = INSTR_W'(2);
  localparam logic [INSTR_W-1:0] OP_SHOW     = INSTR_W'(4);

  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, EXEC} state_t;

  state_t             state_q;
  logic [7:0]         cnt_q;
  logic [BCW-1:0]     bit_q;
  logic [NBITS-1:0]   sr_q;
  logic [PW-1:0]      led_q;
  logic [DATA_W:0]    disp_q;
  logic [DATA_W-1:0]  acc_q;
  logic               valid_q;
  logic               error_q;
  logic               busy_q;

  logic [PW-1:0]      payload;
  logic [DATA_W-1:0]  data_f;
  logic [INSTR_W-1:0] instr_f;
  logic [DATA_W-1:0]  acc_d;
  logic               parity_ok;
  logic               tick;
  logic               start_d;

  // Field extraction and helper terms for the sequencer.
  assign payload = sr_q[NBITS-1 -: PW];
  assign data_f  = payload[PW-1 -: DATA_W];
  assign instr_f = payload[INSTR_W-1:0];
  assign acc_d   = acc_q + data_f;
  assign tick    = (cnt_q == 8'd0);
  // EXEC also watches the line so a start bit right after the stop bit is not lost.
  assign start_d = ((state_q == IDLE) || (state_q == EXEC)) && !bus.transmission;
`ifdef FRAME_RX_PARITY_EN
  assign parity_ok = ~(^sr_q);
`else
  assign parity_ok = 1'b1;
`endif

  // Frame sequencer: bit timing, deserialisation, stop/parity check, instruction execute.
  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= '0;
      sr_q    <= '0;
      led_q   <= '0;
      disp_q  <= BLANK;
      acc_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
        end
        START: begin
          if (tick) begin
            if (bus.transmission) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= SHIFT;
              cnt_q   <= BIT_RELOAD;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            sr_q  <= {sr_q[NBITS-2:0], bus.transmission};
            cnt_q <= BIT_RELOAD;
            if (bit_q == '0) state_q <= STOP;
            else             bit_q   <= bit_q - BCW'(1);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (bus.transmission && parity_ok) begin
              state_q <= EXEC;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        EXEC: begin
          led_q   <= payload;
          valid_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          case (instr_f)
            OP_CLEAR: begin
              disp_q <= BLANK;
              acc_q  <= '0;
            end
            OP_SHOW: begin
              disp_q <= {1'b0, data_f};
              acc_q  <= data_f;
            end
            OP_ADD: begin
              disp_q <= {1'b0, acc_d};
              acc_q  <= acc_d;
            end
            default: begin
            end
          endcase
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (start_d) begin
        busy_q <= 1'b1;
        bit_q  <= LAST_IDX;
        if (CLKS_PER_BIT == 1) begin
          state_q <= SHIFT;
          cnt_q   <= 8'd0;
        end else begin
          state_q <= START;
          cnt_q   <= HALF_RELOAD;
        end
      end
    end
  end

  assign bus.ledData    = led_q;
  assign bus.display    = disp_q;
  assign bus.frameValid = valid_q;
  assign bus.frameError = error_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: bit-rate and 4x-oversampled instances (plus an 8-bit
// data instance when FRAME_RX_PARITY_EN is defined), scoreboard-checked.
module tb_frame_rx;

`ifdef FRAME_RX_PARITY_EN
  localparam int NDUT = 3;
`else
  localparam int NDUT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tx0, tx1, tx2;

  int total = 0;
  int bad   = 0;

  int sb_led[3][$];
  int sb_disp[3][$];
  int disp_m[3];
  int acc_m[3];
  int led_m[3];
  int fv_cnt[3];
  int fe_cnt[3];
  int exp_fv[3];
  int exp_fe[3];

  always #5 clk = ~clk;

  frame_rx_if #(.DATA_W(4), .INSTR_W(4)) bus0 ();
  frame_rx_if #(.DATA_W(4), .INSTR_W(4)) bus1 ();
  assign bus0.transmission = tx0;
  assign bus1.transmission = tx1;

  frame_rx #(.DATA_W(4), .INSTR_W(4), .CLKS_PER_BIT(1)) dut0 (
    .clk2(clk), .reset(rst), .bus(bus0));
  frame_rx #(.DATA_W(4), .INSTR_W(4), .CLKS_PER_BIT(4)) dut1 (
    .clk2(clk), .reset(rst), .bus(bus1));

`ifdef FRAME_RX_PARITY_EN
  frame_rx_if #(.DATA_W(8), .INSTR_W(4)) bus2 ();
  assign bus2.transmission = tx2;
  frame_rx #(.DATA_W(8), .INSTR_W(4), .CLKS_PER_BIT(1)) dut2 (
    .clk2(clk), .reset(rst), .bus(bus2));
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic int dw(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  function automatic logic [31:0] rd_disp(input int d);
    case (d)
      0: return 32'(bus0.display);
      1: return 32'(bus1.display);
`ifdef FRAME_RX_PARITY_EN
      default: return 32'(bus2.display);
`else
      default: return 32'hFFFF_FFFF;
`endif
    endcase
  endfunction

  function automatic logic [31:0] rd_led(input int d);
    case (d)
      0: return 32'(bus0.ledData);
      1: return 32'(bus1.ledData);
`ifdef FRAME_RX_PARITY_EN
      default: return 32'(bus2.ledData);
`else
      default: return 32'hFFFF_FFFF;
`endif
    endcase
  endfunction

  function automatic logic [31:0] rd_busy(input int d);
    case (d)
      0: return 32'(bus0.busy);
      1: return 32'(bus1.busy);
`ifdef FRAME_RX_PARITY_EN
      default: return 32'(bus2.busy);
`else
      default: return 32'hFFFF_FFFF;
`endif
    endcase
  endfunction

  task automatic on_valid(input int d, input logic [31:0] led, input logic [31:0] disp);
    fv_cnt[d]++;
    if (sb_led[d].size() == 0) begin
      chk($sformatf("valid_unexpected%0d", d), 32'(sb_led[d].size()), 32'd1);
    end else begin
      chk($sformatf("led_at_valid%0d", d), led, 32'(sb_led[d].pop_front()));
      chk($sformatf("disp_at_valid%0d", d), disp, 32'(sb_disp[d].pop_front()));
    end
  endtask

  // Output monitors sample on the falling edge.
  always @(negedge clk) if (!rst) begin
    if (bus0.frameValid) on_valid(0, 32'(bus0.ledData), 32'(bus0.display));
    if (bus0.frameError) fe_cnt[0]++;
    if (bus1.frameValid) on_valid(1, 32'(bus1.ledData), 32'(bus1.display));
    if (bus1.frameError) fe_cnt[1]++;
`ifdef FRAME_RX_PARITY_EN
    if (bus2.frameValid) on_valid(2, 32'(bus2.ledData), 32'(bus2.display));
    if (bus2.frameError) fe_cnt[2]++;
`endif
  end

  task automatic set_tx(input int d, input logic b);
    case (d)
      0: tx0 = b;
      1: tx1 = b;
      default: tx2 = b;
    endcase
  endtask

  task automatic drive_bit(input int d, input logic b);
    set_tx(d, b);
    repeat (cpb(d)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      disp_m[d] = 1 << dw(d);
      acc_m[d]  = 0;
      led_m[d]  = 0;
    end
  endtask

  task automatic model_exec(input int d, input int data, input int instr);
    int mask = (1 << dw(d)) - 1;
    case (instr)
      1: begin disp_m[d] = 1 << dw(d); acc_m[d] = 0; end
      4: begin acc_m[d] = data; disp_m[d] = data; end
      2: begin acc_m[d] = (acc_m[d] + data) & mask; disp_m[d] = acc_m[d]; end
      default: ;
    endcase
    led_m[d] = (data << 4) | instr;
    sb_led[d].push_back(led_m[d]);
    sb_disp[d].push_back(disp_m[d]);
    exp_fv[d]++;
  endtask

  task automatic send_frame(input int d, input int data, input int instr,
                            input bit stop_bit, input bit par_flip, input int gap);
    bit bits[$];
    bit p;
    bit good;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = dw(d) - 1; i >= 0; i--) begin
      bits.push_back(data[i]);
      p ^= data[i];
    end
    for (int i = 3; i >= 0; i--) begin
      bits.push_back(instr[i]);
      p ^= instr[i];
    end
`ifdef FRAME_RX_PARITY_EN
    bits.push_back(p ^ par_flip);
    good = stop_bit && !par_flip;
`else
    good = stop_bit && (par_flip || !par_flip);
`endif
    bits.push_back(stop_bit);
    if (good) model_exec(d, data, instr);
    else      exp_fe[d]++;
    foreach (bits[i]) drive_bit(d, bits[i]);
    set_tx(d, 1'b1);
    repeat (gap) drive_bit(d, 1'b1);
  endtask

  task automatic settle(input int d, input string tag);
    repeat (4 * cpb(d) + 3) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 32'(sb_led[d].size()), 32'd0);
    chk({tag, "_led"}, rd_led(d), 32'(led_m[d]));
    chk({tag, "_disp"}, rd_disp(d), 32'(disp_m[d]));
    chk({tag, "_busy"}, rd_busy(d), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    tx0 = 1'b1; tx1 = 1'b1; tx2 = 1'b1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      fv_cnt[d] = 0; fe_cnt[d] = 0; exp_fv[d] = 0; exp_fe[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(bus0.ledData), 32'd0);
    chk("rst_disp", 32'(bus0.display), 32'd16);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_fv", 32'(bus0.frameValid), 32'd0);
    chk("rst_fe", 32'(bus0.frameError), 32'd0);
    chk("rst_disp1", 32'(bus1.display), 32'd16);
    rst = 1'b0;
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);

    // Bit-rate instance: SHOW, ADD with wrap, CLEAR.
    send_frame(0, 'hB, 4, 1'b1, 1'b0, 2); settle(0, "show");
    chk("show_led_b4", rd_led(0), 32'h0B4);
    send_frame(0, 7, 2, 1'b1, 1'b0, 2);   settle(0, "add");
    send_frame(0, 5, 1, 1'b1, 1'b0, 2);   settle(0, "clear");
    send_frame(0, 'hB, 4, 1'b1, 1'b0, 2); settle(0, "show2");
    // Stop-bit error keeps outputs.
    send_frame(0, 3, 4, 1'b0, 1'b0, 3);   settle(0, "stoperr");
    chk("stoperr_fe", 32'(fe_cnt[0]), 32'd1);
    // Unknown opcode updates only ledData.
    send_frame(0, 3, 7, 1'b1, 1'b0, 2);   settle(0, "nop");
    // Back-to-back frames, no idle gap.
    send_frame(0, 3, 4, 1'b1, 1'b0, 0);
    send_frame(0, 1, 2, 1'b1, 1'b0, 2);   settle(0, "b2b");

    // Reset after five payload bits abandons the frame.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1); drive_bit(0, 1'b0); drive_bit(0, 1'b1);
    drive_bit(0, 1'b1); drive_bit(0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_led", 32'(bus0.ledData), 32'd0);
    chk("midrst_disp", 32'(bus0.display), 32'd16);
    chk("midrst_busy", 32'(bus0.busy), 32'd0);
    rst = 1'b0;
    tx0 = 1'b1;
    model_reset();
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    send_frame(0, 3, 4, 1'b1, 1'b0, 2);   settle(0, "after_rst");

    // Oversampled instance: one-cycle glitch is rejected.
    tx1 = 1'b0;
    @(posedge clk);
    #1;
    tx1 = 1'b1;
    chk("glitch_busy_hi", rd_busy(1), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("glitch_busy_lo", rd_busy(1), 32'd0);
    drive_bit(1, 1'b1);
    send_frame(1, 'hB, 4, 1'b1, 1'b0, 2); settle(1, "os_show");
    send_frame(1, 7, 2, 1'b1, 1'b0, 0);
    send_frame(1, 4, 2, 1'b1, 1'b0, 2);   settle(1, "os_b2b");

`ifdef FRAME_RX_PARITY_EN
    drive_bit(2, 1'b1);
    send_frame(2, 'hA5, 4, 1'b1, 1'b0, 2); settle(2, "par_ok");
    send_frame(2, 'hA5, 4, 1'b1, 1'b1, 3); settle(2, "par_bad");
`endif

    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("fv_count%0d", d), 32'(fv_cnt[d]), 32'(exp_fv[d]));
      chk($sformatf("fe_count%0d", d), 32'(fe_cnt[d]), 32'(exp_fe[d]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
